// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a single-clock FIFO. Burst-locks on req_last=0,
// forwards the winning beat with zero latency, tags it with its source ID and counts stall cycles.
module fifo_wr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int ID_WIDTH        = $clog2(NUM_REQ),
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           fifo_wr_id,
  input  logic                          fifo_full,
  output logic                          locked,
  output logic [STALL_CNT_WIDTH-1:0]    stall_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] last_grant, last_grant_next;
  logic [ID_WIDTH-1:0] lock_id, lock_id_next;
  logic [ID_WIDTH-1:0] rr_sel, rr_idx, sel;
  logic                rr_found;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester after last_grant, wrapping.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rr_sel   = last_grant;
    rr_idx   = last_grant;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_sel   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign sel = (state == LOCKED) ? lock_id : rr_sel;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      lock_id    <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      lock_id    <= lock_id_next;
    end
  end

  // Next-state logic: only an accepted beat moves the lock or the round-robin pointer.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    lock_id_next    = lock_id;
    if (fifo_wr_en) begin
      unique case (state)
        IDLE: begin
          if (req_last[sel]) begin
            last_grant_next = sel;
          end else begin
            state_next   = LOCKED;
            lock_id_next = sel;
          end
        end
        LOCKED: begin
          if (req_last[sel]) begin
            state_next      = IDLE;
            last_grant_next = lock_id;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs: a locked grant stays ready through bubbles so the burst owner can resume at once.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && !fifo_full && (ID_WIDTH'(i) == sel) &&
          (state == LOCKED || req_valid[i])) begin
        req_ready[i] = 1'b1;
      end
    end
    fifo_wr_en   = req_valid[sel] && req_ready[sel];
    fifo_wr_data = data_arr[sel];
    fifo_wr_id   = sel;
    locked       = !rst && (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|req_valid) && fifo_full && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: scoreboard of expected writes checked by a monitor,
// plus a 16-deep behavioural FIFO that drives fifo_full and returns read data.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int SW = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [NR-1:0]     rv = '0;
  logic [NR-1:0]     rl = '0;
  logic [DW-1:0]     d [NR];
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [IW-1:0]     fifo_wr_id;
  logic              fifo_full;
  logic              locked;
  logic [SW-1:0]     stall_cnt;

  logic force_full = 1'b0;
  logic model_full = 1'b0;
  assign fifo_full = force_full | model_full;
  assign req_data  = {d[3], d[2], d[1], d[0]};

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .STALL_CNT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_data(req_data), .req_last(rl), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_id(fifo_wr_id),
    .fifo_full(fifo_full), .locked(locked), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] rd_exp [$];
  logic [DW-1:0] fifo_q [$];
  int checks = 0;
  int errors = 0;

  logic          wr_pend = 1'b0;
  logic [DW-1:0] wr_pend_data = '0;
  logic          rd_pend = 1'b0;
  logic [DW-1:0] rd_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input int id, input logic [DW-1:0] data);
    exp_t e;
    e.id   = IW'(id);
    e.data = data;
    exp_q.push_back(e);
    rd_exp.push_back(data);
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    rd_exp.delete();
    model_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_fifo();
    force_full = 1'b0;
    rst = 1'b1;
    rv  = '1;
    rl  = '1;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    cyc();
    rst = 1'b0;
    rv  = '0;
    @(negedge clk);
    check("post_reset_stall", 32'(stall_cnt), 32'h0);
    cyc();
  endtask

  // Monitor: every DUT write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_pend = fifo_wr_en;
    wr_pend_data = fifo_wr_data;
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got id %0h data %0h expected no write at %0t",
                 fifo_wr_id, fifo_wr_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_id", 32'(fifo_wr_id), 32'(e.id));
        check("wr_data", 32'(fifo_wr_data), 32'(e.data));
      end
    end
  end

  // Behavioural FIFO: write/read take effect on the rising edge, full updates just after.
  always @(posedge clk) begin
    if (wr_pend && fifo_q.size() < DEPTH) fifo_q.push_back(wr_pend_data);
    if (rd_pend && fifo_q.size() > 0) rd_val = fifo_q.pop_front();
    #1;
    model_full = (fifo_q.size() >= DEPTH);
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [DW-1:0] dv;
    for (int i = 0; i < NR; i++) d[i] = '0;
    cyc();

    // 1: single beat from requester 1, then read it back.
    do_reset();
    rv = 4'b0010; rl = 4'b0010; d[1] = 16'h1234;
    expect_wr(1, 16'h1234);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h2);
    check("t1_locked", 32'(locked), 32'h0);
    cyc();
    rv = '0;
    rd_pend = 1'b1;
    cyc();
    rd_pend = 1'b0;
    check("t1_read", 32'(rd_val), 32'h1234);
    check("t1_sb_empty", 32'(exp_q.size()), 32'h0);

    // 2: all four valid single-beat -> 0,1,2,3,0,1.
    do_reset();
    rv = 4'b1111; rl = 4'b1111;
    for (int i = 0; i < NR; i++) d[i] = 16'h2000 + 16'(i);
    for (int c = 0; c < 6; c++) begin
      expect_wr(order[c], 16'h2000 + 16'(order[c]));
      @(negedge clk);
      check("t2_ready", 32'(req_ready), 32'(1) << order[c]);
      check("t2_locked", 32'(locked), 32'h0);
      cyc();
    end
    rv = '0;
    check("t2_sb_empty", 32'(exp_q.size()), 32'h0);

    // 3: req2 burst A0..A2, req0 joins in cycle 2 and waits for the burst to end.
    do_reset();
    rl = 4'b0000; rv = 4'b0100; d[2] = 16'h00A0;
    expect_wr(2, 16'h00A0);
    @(negedge clk); check("t3_locked_c1", 32'(locked), 32'h0); cyc();
    rv = 4'b0101; d[2] = 16'h00A1; d[0] = 16'h00C0; rl = 4'b0001;
    expect_wr(2, 16'h00A1);
    @(negedge clk);
    check("t3_locked_c2", 32'(locked), 32'h1);
    check("t3_ready_c2", 32'(req_ready), 32'h4);
    cyc();
    d[2] = 16'h00A2; rl = 4'b0101;
    expect_wr(2, 16'h00A2);
    @(negedge clk); check("t3_locked_c3", 32'(locked), 32'h1); cyc();
    rv = 4'b0001;
    expect_wr(0, 16'h00C0);
    @(negedge clk); check("t3_locked_c4", 32'(locked), 32'h0); cyc();
    rv = '0;
    check("t3_sb_empty", 32'(exp_q.size()), 32'h0);

    // 3b: locked requester drops valid mid-burst; req3 must wait through the bubbles.
    do_reset();
    rv = 4'b0010; rl = 4'b1000; d[1] = 16'hB000; d[3] = 16'hB300;
    expect_wr(1, 16'hB000);
    @(negedge clk); check("t3b_ready_c1", 32'(req_ready), 32'h2); cyc();
    rv = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t3b_bubble_ready", 32'(req_ready), 32'h2);
      check("t3b_bubble_locked", 32'(locked), 32'h1);
      cyc();
    end
    rv = 4'b1010; rl = 4'b1010; d[1] = 16'hB001;
    expect_wr(1, 16'hB001);
    @(negedge clk); check("t3b_ready_c4", 32'(req_ready), 32'h2); cyc();
    rv = 4'b1000;
    expect_wr(3, 16'hB300);
    @(negedge clk);
    check("t3b_ready_c5", 32'(req_ready), 32'h8);
    check("t3b_locked_c5", 32'(locked), 32'h0);
    cyc();
    rv = '0;
    check("t3b_sb_empty", 32'(exp_q.size()), 32'h0);

    // 4: FIFO full for 5 cycles with req1 waiting.
    do_reset();
    force_full = 1'b1; rv = 4'b0010; rl = 4'b0010; d[1] = 16'hBEEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_full_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    force_full = 1'b0;
    expect_wr(1, 16'hBEEF);
    @(negedge clk);
    check("t4_ready", 32'(req_ready), 32'h2);
    check("t4_stall", 32'(stall_cnt), 32'd5);
    cyc();
    rv = '0;
    @(negedge clk); check("t4_stall_hold", 32'(stall_cnt), 32'd5); cyc();
    check("t4_sb_empty", 32'(exp_q.size()), 32'h0);

    // 5: reset in the middle of a req3 burst.
    do_reset();
    force_full = 1'b1; rv = 4'b1000; rl = 4'b0000; d[3] = 16'h3000;
    repeat (2) cyc();
    force_full = 1'b0;
    expect_wr(3, 16'h3000);
    @(negedge clk);
    check("t5_stall_pre", 32'(stall_cnt), 32'd2);
    check("t5_ready_c1", 32'(req_ready), 32'h8);
    cyc();
    rst = 1'b1; d[3] = 16'h3001;
    @(negedge clk);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    check("t5_rst_locked", 32'(locked), 32'h0);
    cyc();
    rst = 1'b0; rv = 4'b1001; rl = 4'b0001; d[0] = 16'h0005;
    expect_wr(0, 16'h0005);
    @(negedge clk);
    check("t5_locked_after", 32'(locked), 32'h0);
    check("t5_stall_after", 32'(stall_cnt), 32'h0);
    check("t5_ready_after", 32'(req_ready), 32'h1);
    cyc();
    rv = 4'b1000;
    expect_wr(3, 16'h3001);
    @(negedge clk); cyc();
    rl = 4'b1000; d[3] = 16'h3002;
    expect_wr(3, 16'h3002);
    @(negedge clk); check("t5_locked_burst", 32'(locked), 32'h1); cyc();
    rv = '0;
    @(negedge clk); check("t5_locked_end", 32'(locked), 32'h0); cyc();
    check("t5_sb_empty", 32'(exp_q.size()), 32'h0);

    // 6: alternate req0/req1 until the FIFO fills, hold the 17th beat, then drain.
    do_reset();
    rv = 4'b0011; rl = 4'b1111;
    for (int k = 0; k < DEPTH; k++) begin
      d[0] = 16'h6000 + 16'((k + 1) / 2);
      d[1] = 16'h6100 + 16'(k / 2);
      if (k % 2 == 0) expect_wr(0, 16'h6000 + 16'(k / 2));
      else            expect_wr(1, 16'h6100 + 16'(k / 2));
      @(negedge clk);
      check("t6_fill_ready", 32'(req_ready), 32'(1) << (k % 2));
      cyc();
    end
    d[0] = 16'h6008; d[1] = 16'h6108;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rd_pend = 1'b1;
      @(negedge clk);
      check("t6_full_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    rd_pend = 1'b0;
    dv = rd_exp.pop_front();
    check("t6_read_first", 32'(rd_val), 32'(dv));
    expect_wr(0, 16'h6008);
    @(negedge clk);
    check("t6_held_ready", 32'(req_ready), 32'h1);
    check("t6_stall", 32'(stall_cnt), 32'd3);
    cyc();
    rv = '0;
    for (int r = 0; r < DEPTH; r++) begin
      rd_pend = 1'b1;
      cyc();
      dv = rd_exp.pop_front();
      check("t6_drain", 32'(rd_val), 32'(dv));
    end
    rd_pend = 1'b0;
    check("t6_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO (`async_fifo`, run on one clock) among NUM_REQ requesters.
- Each requester uses a valid/ready handshake with an optional multi-beat burst lock (`req_last`).
- The winning beat is forwarded to the FIFO with zero added latency and tagged with the source ID.
- Sits directly in front of the FIFO write interface; also reports backpressure stall cycles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, payload width; matches FIFO DATA_WIDTH.
- ID_WIDTH, $clog2(NUM_REQ), width of source tag.
- STALL_CNT_WIDTH, 16, width of saturating stall counter.

Ports:
- clk  in  1  single clock; FIFO wr_clk and rd_clk both tied to it.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  beat is final beat of burst (1 = single-beat transfer).
- req_ready  out  NUM_REQ  beat accepted this cycle when valid & ready.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data.
- fifo_wr_id  out  ID_WIDTH  source ID of the beat being written.
- fifo_full  in  1  from FIFO full.
- locked  out  1  arbiter holding grant mid-burst.
- stall_cnt  out  STALL_CNT_WIDTH  cycles with any req_valid while fifo_full; saturating.

Behaviour:
- State: last_grant (ID_WIDTH), lock_id (ID_WIDTH), FSM {IDLE, LOCKED}, stall_cnt.
- Reset (rst high at posedge):
  - FSM=IDLE, last_grant=NUM_REQ-1, lock_id=0, stall_cnt=0.
  - While rst is high: req_ready=0, fifo_wr_en=0, locked=0 (gated combinationally).
- Selection (combinational):
  - IDLE: sel = first i with req_valid[i], searching (last_grant+1) mod NUM_REQ upward with wrap.
  - LOCKED: sel = lock_id regardless of other valids.
- Handshake and outputs:
  - req_ready[i] = !rst && !fifo_full && (i==sel) && (FSM==LOCKED || req_valid[i]).
  - fifo_wr_en = req_valid[sel] && req_ready[sel], same cycle (0 latency).
  - fifo_wr_data = req_data[sel], fifo_wr_id = sel; both don't-care when fifo_wr_en=0.
  - Requesters hold valid, data and last stable until accepted; the arbiter never drops an accepted beat.
- Transitions, on a transfer (fifo_wr_en=1):
  - IDLE, req_last=0 -> LOCKED, lock_id=sel.
  - IDLE, req_last=1 -> stay IDLE, last_grant=sel.
  - LOCKED, req_last=1 -> IDLE, last_grant=lock_id.
  - LOCKED, req_last=0 -> stay LOCKED.
  - No transfer: state unchanged.
- locked = (FSM==LOCKED).
- Boundary conditions:
  - fifo_full: all req_ready=0; lock and last_grant unchanged; no beat lost.
  - Locked requester deasserts valid mid-burst: grant held, bubble cycles, other requesters wait.
  - Single requester valid: served every cycle while FIFO not full.
  - Reset mid-burst: abandons lock; next grant search starts at requester 0.
- stall_cnt: +1 each cycle with (|req_valid) && fifo_full; holds at all-ones (no wrap).

Test Plan (FIFO DATA_WIDTH=16, ADDR_WIDTH=4, depth 16; default params):
1. After reset, req_valid=4'b0010, req_data[1]=16'h1234, req_last[1]=1 -> same cycle req_ready=4'b0010, fifo_wr_en=1, fifo_wr_id=1, fifo_wr_data=16'h1234; FIFO read returns 16'h1234.
2. All four valid, single-beat, held continuously -> grant order 0,1,2,3,0,1; one write per cycle; locked stays 0.
3. req2 burst 16'hA0,16'hA1,16'hA2 (last on A2) and req0 valid from cycle 2 -> ids 2,2,2 then 0; locked=1 after A0 through the A2 cycle, then 0.
4. fifo_full=1 for 5 cycles with req1 valid (16'hBEEF) -> fifo_wr_en=0, req_ready=0, stall_cnt=5; 16'hBEEF written in the first cycle full drops.
5. rst pulsed during beat 2 of a req3 burst; req0 and req3 valid afterwards -> locked=0, stall_cnt=0, first grant is id 0.
6. 16 writes alternating req0/req1 until full=1, then drain 16 reads -> data order matches grant order; the 17th beat is held, then accepted after the first read.
